ffn_layer_sequencer: RTL and testbench

- Time-multiplexed controller for one fully-connected layer. It computes a LANES-wide slice of output neurons per pass over a shared bank of external pipelined multipliers (multiply2-style, LANES instances).
- Latches the input neuron vector and streams weights from an external weight memory.
- Accumulates the products into ACC_WIDTH sums and hands each group of output neurons downstream over a valid/ready handshake.
- Sits between the input activation buffer and the softmax stage.

---
 rtl/ffn_layer_sequencer_pkg.sv | 26 ++
 rtl/ffn_layer_sequencer_if.sv | 48 ++++
 rtl/ffn_lane_acc.sv | 41 ++++
 rtl/ffn_layer_sequencer.sv | 178 +++++++++++++++++
 tb/tb_ffn_layer_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ffn_layer_sequencer_pkg.sv
// ffn_layer_sequencer_pkg
//   Shared definitions for the fully-connected layer sequencer: default
//   operand width, accumulator/address width helpers and the FSM state type.
//   No ports.
package ffn_layer_sequencer_pkg;

    localparam int FFN_WIDTH = 8;

    // Full-precision product plus enough headroom for NUM_INPUT_N additions.
    function automatic int acc_width(input int fw, input int n);
        return 2 * fw + $clog2(n);
    endfunction

    // Address/index width with a floor of one bit.
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        OUTPUT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/ffn_layer_sequencer_if.sv
// ffn_layer_sequencer_if
//   Bundles the sequencer's start handshake, weight-memory port, multiplier
//   bank port, result handshake and status.
//   master: sequencer side (drives start_ready, w_rd_en/w_addr, mul_a/mul_b,
//           out_valid/out_data/out_index/out_last, busy)
//   slave : environment side (drives start_valid, input_neurons, w_rd_data,
//           mul_p, out_ready)
interface ffn_layer_sequencer_if #(
    parameter int FFN_WIDTH    = ffn_layer_sequencer_pkg::FFN_WIDTH,
    parameter int NUM_INPUT_N  = 8,
    parameter int NUM_OUTPUT_N = 4,
    parameter int LANES        = 2,
    parameter int ACC_WIDTH    = ffn_layer_sequencer_pkg::acc_width(FFN_WIDTH, NUM_INPUT_N)
);
    import ffn_layer_sequencer_pkg::*;

    localparam int AW = addr_width(NUM_INPUT_N * NUM_OUTPUT_N / LANES);
    localparam int GW = addr_width(NUM_OUTPUT_N / LANES);

    logic                             start_valid;
    logic                             start_ready;
    logic [FFN_WIDTH*NUM_INPUT_N-1:0] input_neurons;
    logic                             w_rd_en;
    logic [AW-1:0]                    w_addr;
    logic [FFN_WIDTH*LANES-1:0]       w_rd_data;
    logic [FFN_WIDTH-1:0]             mul_a;
    logic [FFN_WIDTH*LANES-1:0]       mul_b;
    logic [2*FFN_WIDTH*LANES-1:0]     mul_p;
    logic                             out_valid;
    logic                             out_ready;
    logic [ACC_WIDTH*LANES-1:0]       out_data;
    logic [GW-1:0]                    out_index;
    logic                             out_last;
    logic                             busy;

    modport master (
        input  start_valid, input_neurons, w_rd_data, mul_p, out_ready,
        output start_ready, w_rd_en, w_addr, mul_a, mul_b,
               out_valid, out_data, out_index, out_last, busy
    );

    modport slave (
        output start_valid, input_neurons, w_rd_data, mul_p, out_ready,
        input  start_ready, w_rd_en, w_addr, mul_a, mul_b,
               out_valid, out_data, out_index, out_last, busy
    );

endinterface

// File: rtl/ffn_lane_acc.sv
// ffn_lane_acc
//   One output-neuron accumulator: sign-extends a signed product to the
//   accumulator width and adds it when enabled; synchronous clear.
//   Ports: clock_i, reset_i (async, active-high), clear_i, en_i,
//          prod_i (signed product), acc_o (running signed sum).
module ffn_lane_acc #(
    parameter int PW        = 16,
    parameter int ACC_WIDTH = 19
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [PW-1:0]        prod_i,
    output logic [ACC_WIDTH-1:0] acc_o
);
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] prod_ext;

    assign prod_ext = {{(ACC_WIDTH - PW){prod_i[PW-1]}}, prod_i};

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ffn_layer_sequencer.sv
// ffn_layer_sequencer
//   Time-multiplexed controller for one fully-connected layer. Each pass
//   streams NUM_INPUT_N weight words through LANES external pipelined
//   multipliers and accumulates one group of LANES output neurons, then
//   hands the group downstream over a valid/ready handshake.
//   Ports: clock_i, reset_i (async, active-high), bus (master modport of
//          ffn_layer_sequencer_if: start handshake, weight read port,
//          multiplier operands/products, result handshake, busy).
//   Build option: define FFN_SEQ_RELU_EN to clamp negative lane sums to 0.
//
//   state  | meaning
//   IDLE   | waiting for an input vector, start_ready=1
//   ISSUE  | one weight read per cycle, k = 0..NUM_INPUT_N-1
//   DRAIN  | reads done, waiting for in-flight products to land
//   OUTPUT | group result presented until out_ready
module ffn_layer_sequencer
    import ffn_layer_sequencer_pkg::*;
#(
    parameter int NUM_INPUT_N  = 8,
    parameter int NUM_OUTPUT_N = 4,
    parameter int LANES        = 2,
    parameter int FFN_WIDTH    = ffn_layer_sequencer_pkg::FFN_WIDTH,
    parameter int PIPE_LAT     = 2,
    parameter int ACC_WIDTH    = ffn_layer_sequencer_pkg::acc_width(FFN_WIDTH, NUM_INPUT_N)
) (
    input logic                   clock_i,
    input logic                   reset_i,
    ffn_layer_sequencer_if.master bus
);
    localparam int NG = NUM_OUTPUT_N / LANES;
    localparam int KW = addr_width(NUM_INPUT_N);
    localparam int GW = addr_width(NG);
    localparam int AW = addr_width(NUM_INPUT_N * NG);
    localparam int PW = 2 * FFN_WIDTH;

    if (NUM_OUTPUT_N % LANES != 0) begin : g_bad_lanes
        $error("NUM_OUTPUT_N must be a multiple of LANES");
    end
    if (NUM_INPUT_N < 2 || PIPE_LAT < 1) begin : g_bad_depth
        $error("NUM_INPUT_N must be >= 2 and PIPE_LAT >= 1");
    end

    seq_state_e                       state_q, state_d;
    logic [KW-1:0]                    k_q, k_d, rd_k_q;
    logic [GW-1:0]                    group_q, group_d;
    logic [FFN_WIDTH*NUM_INPUT_N-1:0] nrn_q, nrn_d;
    logic                             rd_pend_q, rd_pend_d;
    logic [PIPE_LAT:0]                vld_q, vld_d;
    logic [FFN_WIDTH-1:0]             mul_a_q, mul_a_d;
    logic [FFN_WIDTH*LANES-1:0]       mul_b_q, mul_b_d;
    logic                             acc_clr;
    logic                             last_k, last_grp;
    logic [LANES-1:0][ACC_WIDTH-1:0]  acc_w;

    assign last_k   = (k_q == KW'(NUM_INPUT_N - 1));
    assign last_grp = (group_q == GW'(NG - 1));

    // rd_pend marks w_rd_data valid this cycle; vld[0] marks mul_a/mul_b
    // valid and vld[PIPE_LAT] marks the matching mul_p.
    assign rd_pend_d = (state_q == ISSUE);
    assign vld_d     = {vld_q[PIPE_LAT-1:0], rd_pend_q};

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        group_d = group_q;
        nrn_d   = nrn_q;
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    state_d = ISSUE;
                    nrn_d   = bus.input_neurons;
                    group_d = '0;
                    k_d     = '0;
                end
            end
            ISSUE: begin
                k_d = k_q + KW'(1);
                if (last_k) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Look at the next-cycle pipeline contents so OUTPUT is
                // entered on the same edge the final product is summed.
                if (vld_d == '0) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    if (last_grp) begin
                        state_d = IDLE;
                    end else begin
                        group_d = group_q + GW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mul_a_d = '0;
        mul_b_d = '0;
        if (rd_pend_q) begin
            mul_a_d = nrn_q[FFN_WIDTH*rd_k_q +: FFN_WIDTH];
            mul_b_d = bus.w_rd_data;
        end
    end

    assign acc_clr = (state_q != ISSUE) && (state_d == ISSUE);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            k_q       <= '0;
            rd_k_q    <= '0;
            group_q   <= '0;
            nrn_q     <= '0;
            rd_pend_q <= 1'b0;
            vld_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            rd_k_q    <= k_q;
            group_q   <= group_d;
            nrn_q     <= nrn_d;
            rd_pend_q <= rd_pend_d;
            vld_q     <= vld_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ffn_lane_acc #(
            .PW        (PW),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_acc (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .clear_i (acc_clr),
            .en_i    (vld_q[PIPE_LAT]),
            .prod_i  (bus.mul_p[PW*l +: PW]),
            .acc_o   (acc_w[l])
        );
    end

    always_comb begin
        bus.out_data = '0;
        for (int l = 0; l < LANES; l++) begin
            bus.out_data[ACC_WIDTH*l +: ACC_WIDTH] = acc_w[l];
`ifdef FFN_SEQ_RELU_EN
            if (acc_w[l][ACC_WIDTH-1]) begin
                bus.out_data[ACC_WIDTH*l +: ACC_WIDTH] = '0;
            end
`else
`endif
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.w_rd_en     = (state_q == ISSUE);
    assign bus.w_addr      = (state_q == ISSUE)
                             ? AW'(int'(group_q) * NUM_INPUT_N + int'(k_q)) : '0;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.out_valid   = (state_q == OUTPUT);
    assign bus.out_index   = group_q;
    assign bus.out_last    = (state_q == OUTPUT) && last_grp;

endmodule

// File: tb/tb_ffn_layer_sequencer.sv
module tb_ffn_layer_sequencer;
    import ffn_layer_sequencer_pkg::*;

    localparam int N    = 8;
    localparam int NO   = 4;
    localparam int L    = 2;
    localparam int FW   = 8;
    localparam int PL   = 2;
    localparam int NG   = NO / L;
    localparam int NW   = N * NG;
    localparam int ACCW = acc_width(FW, N);
    localparam int LAT  = N + PL + 2;

    typedef logic signed [63:0] val_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    ffn_layer_sequencer_if #(.FFN_WIDTH(FW), .NUM_INPUT_N(N), .NUM_OUTPUT_N(NO), .LANES(L)) bus();

    ffn_layer_sequencer #(
        .NUM_INPUT_N(N), .NUM_OUTPUT_N(NO), .LANES(L), .FFN_WIDTH(FW), .PIPE_LAT(PL)
    ) dut (
        .clock_i (clock),
        .reset_i (reset),
        .bus     (bus)
    );

    // Environment: weight memory (1-cycle read) and a PL-deep multiplier bank.
    logic signed [FW-1:0]  wmem [NW][L];
    logic signed [FW-1:0]  nvec [N];
    logic [2*FW*L-1:0]     pipe [PL];
    int                    addr_log[$];

    function automatic logic signed [2*FW-1:0] mul16(input logic signed [FW-1:0] a,
                                                      input logic signed [FW-1:0] b);
        logic signed [2*FW-1:0] x, y;
        x = a;
        y = b;
        return x * y;
    endfunction

    always @(posedge clock) begin
        if (bus.w_rd_en) begin
            for (int l = 0; l < L; l++) bus.w_rd_data[FW*l +: FW] <= wmem[bus.w_addr][l];
        end
    end

    always @(posedge clock) begin
        for (int l = 0; l < L; l++)
            pipe[0][2*FW*l +: 2*FW] <= mul16(bus.mul_a, bus.mul_b[FW*l +: FW]);
        for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mul_p = pipe[PL-1];

    always @(negedge clock) if (bus.w_rd_en) addr_log.push_back(int'(bus.w_addr));

    // Reference: dot product of the latched vector with the group's weights.
    function automatic longint exp_lane(input int g, input int l);
        longint s = 0;
        for (int k = 0; k < N; k++) s += longint'(nvec[k]) * longint'(wmem[g*N+k][l]);
`ifdef FFN_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic check(input string tag, input val_t obs, input val_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < N; k++) nvec[k] = FW'($urandom);
        for (int w = 0; w < NW; w++)
            for (int l = 0; l < L; l++) wmem[w][l] = FW'($urandom);
    endtask

    // Called just after a posedge; returns the cycle count of the accept edge.
    task automatic start_vec(input bit hold, output int hs);
        logic [FW*N-1:0] v;
        for (int k = 0; k < N; k++) v[FW*k +: FW] = nvec[k];
        bus.input_neurons = v;
        bus.start_valid   = 1'b1;
        hs = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (bus.start_ready) begin
                hs = cyc + 1;
                break;
            end
        end
        check("start_accepted", val_t'(hs >= 0), val_t'(1));
        @(posedge clock);
        #1;
        if (!hold) bus.start_valid = 1'b0;
    endtask

    task automatic collect(input int hs_in, input int stall0, input bit hold, output int last_hs);
        int hs = hs_in;
        for (int g = 0; g < NG; g++) begin
            int t = -1;
            if (g == 0 && stall0 > 0) bus.out_ready = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clock);
                if (bus.out_valid) begin
                    t = cyc;
                    break;
                end
            end
            check("latency", val_t'(t - hs), val_t'(LAT));
            check("out_index", val_t'(bus.out_index), val_t'(g));
            check("out_last", val_t'(bus.out_last), val_t'(g == NG - 1));
            check("rd_en_in_output", val_t'(bus.w_rd_en), val_t'(0));
            for (int l = 0; l < L; l++)
                check("out_data", val_t'($signed(bus.out_data[ACCW*l +: ACCW])), val_t'(exp_lane(g, l)));
            if (g == 0 && stall0 > 0) begin
                for (int s = 1; s < stall0; s++) begin
                    @(negedge clock);
                    check("stall_valid", val_t'(bus.out_valid), val_t'(1));
                    check("stall_rd_en", val_t'(bus.w_rd_en), val_t'(0));
                    check("stall_index", val_t'(bus.out_index), val_t'(0));
                    for (int l = 0; l < L; l++)
                        check("stall_data", val_t'($signed(bus.out_data[ACCW*l +: ACCW])),
                              val_t'(exp_lane(0, l)));
                end
                bus.out_ready = 1'b1;
            end
            hs = cyc + 1;
            @(posedge clock);
            #1;
        end
        last_hs = hs;
        if (!hold) begin
            @(negedge clock);
            check("idle_busy", val_t'(bus.busy), val_t'(0));
            check("idle_start_ready", val_t'(bus.start_ready), val_t'(1));
            check("idle_mul_a", val_t'(bus.mul_a), val_t'(0));
            @(posedge clock);
            #1;
        end
    endtask

    task automatic run_vec(input int stall0);
        int hs, last;
        start_vec(1'b0, hs);
        collect(hs, stall0, 1'b0, last);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_ready"}, val_t'(bus.start_ready), val_t'(1));
        check({tag, "_busy"}, val_t'(bus.busy), val_t'(0));
        check({tag, "_out_valid"}, val_t'(bus.out_valid), val_t'(0));
        check({tag, "_rd_en"}, val_t'(bus.w_rd_en), val_t'(0));
        check({tag, "_w_addr"}, val_t'(bus.w_addr), val_t'(0));
        check({tag, "_mul_a"}, val_t'(bus.mul_a), val_t'(0));
        check({tag, "_mul_b"}, val_t'(bus.mul_b), val_t'(0));
        check({tag, "_out_data"}, val_t'(bus.out_data), val_t'(0));
        check({tag, "_out_last"}, val_t'(bus.out_last), val_t'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, hs2, last;
        logic [FW*N-1:0] alt;

        bus.start_valid   = 1'b0;
        bus.out_ready     = 1'b1;
        bus.input_neurons = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Single vector: ones against weights 1 (group 0) and 2 (group 1).
        for (int k = 0; k < N; k++) nvec[k] = 8'sd1;
        for (int w = 0; w < NW; w++)
            for (int l = 0; l < L; l++) wmem[w][l] = (w < N) ? 8'sd1 : 8'sd2;
        run_vec(0);

        // Signed extremes.
        for (int k = 0; k < N; k++) nvec[k] = -8'sd128;
        for (int w = 0; w < NW; w++)
            for (int l = 0; l < L; l++) wmem[w][l] = -8'sd128;
        run_vec(0);
        for (int w = 0; w < NW; w++)
            for (int l = 0; l < L; l++) wmem[w][l] = 8'sd127;
        run_vec(0);

        // Backpressure on group 0.
        fill_rand();
        run_vec(20);

        // Start pulse while busy must be ignored.
        fill_rand();
        start_vec(1'b0, hs);
        repeat (3) @(negedge clock);
        alt = {$urandom, $urandom};
        bus.input_neurons = alt;
        bus.start_valid   = 1'b1;
        check("busy_start_ready", val_t'(bus.start_ready), val_t'(0));
        check("busy_flag", val_t'(bus.busy), val_t'(1));
        @(posedge clock);
        #1;
        bus.start_valid = 1'b0;
        collect(hs, 0, 1'b0, last);

        // Async reset while draining, then a fresh vector.
        fill_rand();
        start_vec(1'b0, hs);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (cyc == hs + 9) break;
        end
        check("drain_busy", val_t'(bus.busy), val_t'(1));
        check("drain_rd_en", val_t'(bus.w_rd_en), val_t'(0));
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        fill_rand();
        run_vec(0);

        // Back-to-back vectors with start_valid held high.
        fill_rand();
        addr_log.delete();
        start_vec(1'b1, hs);
        collect(hs, 0, 1'b1, last);
        for (int k = 0; k < N; k++) nvec[k] = FW'($urandom);
        start_vec(1'b1, hs2);
        bus.start_valid = 1'b0;
        check("b2b_accept_cycle", val_t'(hs2), val_t'(last + 1));
        collect(hs2, 0, 1'b0, last);
        check("b2b_addr_count", val_t'(addr_log.size()), val_t'(2 * NW));
        for (int i = 0; i < addr_log.size() && i < 2 * NW; i++)
            check("b2b_w_addr", val_t'(addr_log[i]), val_t'(i % NW));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
